// File: rtl/i2c_target_fifo.sv
// I2C target with an RX FIFO for write bytes and a TX FIFO for read bytes.
// SCL/SDA are oversampled on clk_i; sda_o is an open-drain enable (0 = pull low).
module i2c_target_fifo #(
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_o,
    input  logic [I2C_ADDR_WIDTH-1:0] own_addr_i,
    output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    input  logic [I2C_DATA_WIDTH-1:0] tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      addr_hit_o,
    output logic                      op_o,
    output logic                      busy_o,
    output logic                      rx_overflow_o,
    output logic                      tx_underrun_o
);

    localparam int AW = I2C_ADDR_WIDTH;
    localparam int DW = I2C_DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = (AW + 1 > DW) ? AW + 1 : DW;
    localparam int CW = $clog2(SW + 2);
    localparam logic [PW:0] DEPTH_CNT = FIFO_DEPTH[PW:0];

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic [SW-1:0]   shift;
    logic            ack_ok;
    logic            nack;

    logic [SYNC_STAGES:0] scl_sync;
    logic [SYNC_STAGES:0] sda_sync;
    logic scl_s, scl_p, sda_s, sda_p;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [DW-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wr, rx_rd;
    logic [PW:0]   rx_count;
    logic          rx_full, rx_empty, rx_push, rx_pop, rx_space;
    logic [DW-1:0] rx_byte;

    logic [DW-1:0] tx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wr, tx_rd;
    logic [PW:0]   tx_count;
    logic          tx_full, tx_empty, tx_push, tx_pop, load_req;
    logic [DW-1:0] load_byte;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-1:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-1:0], sda_i};
        end
    end

    // The top flop holds the previous synchronised sample; edges compare it with the newest.
    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign scl_p     = scl_sync[SYNC_STAGES];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign sda_p     = sda_sync[SYNC_STAGES];
    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

    assign rx_full    = (rx_count == DEPTH_CNT);
    assign rx_empty   = (rx_count == '0);
    assign rx_valid_o = ~rx_empty;
    assign rx_data_o  = rx_mem[rx_rd];
    assign rx_pop     = rx_valid_o & rx_ready_i;
    assign rx_space   = ~rx_full | rx_pop;
    assign rx_byte    = {shift[DW-2:0], sda_s};
    assign rx_push    = scl_rise && (state == WR_DATA) && (bit_cnt == CW'(DW - 1)) && rx_space;

    assign tx_full    = (tx_count == DEPTH_CNT);
    assign tx_empty   = (tx_count == '0);
    assign tx_ready_o = ~tx_full;
    assign tx_push    = tx_valid_i & tx_ready_o;
    assign load_req   = scl_fall && (((state == ADDR_ACK) && op_o) || ((state == RD_ACK) && !nack));
    assign tx_pop     = load_req & ~tx_empty;
    assign load_byte  = tx_empty ? '1 : tx_mem[tx_rd];

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wr] <= rx_byte;
        if (tx_push) tx_mem[tx_wr] <= tx_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + PW'(1);
            if (rx_pop)  rx_rd <= rx_rd + PW'(1);
            rx_count <= rx_count + (PW + 1)'(rx_push) - (PW + 1)'(rx_pop);
            if (tx_push) tx_wr <= tx_wr + PW'(1);
            if (tx_pop)  tx_rd <= tx_rd + PW'(1);
            tx_count <= tx_count + (PW + 1)'(tx_push) - (PW + 1)'(tx_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            ack_ok        <= 1'b0;
            nack          <= 1'b0;
            sda_o         <= 1'b1;
            start_o       <= 1'b0;
            stop_o        <= 1'b0;
            addr_hit_o    <= 1'b0;
            op_o          <= 1'b0;
            busy_o        <= 1'b0;
            rx_overflow_o <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            addr_hit_o <= 1'b0;
            if (start_det) begin
                start_o <= 1'b1;
                busy_o  <= 1'b1;
                bit_cnt <= '0;
                sda_o   <= 1'b1;
                state   <= ADDR;
            end else if (stop_det) begin
                stop_o <= 1'b1;
                busy_o <= 1'b0;
                sda_o  <= 1'b1;
                state  <= IDLE;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[SW-2:0], sda_s};
                            bit_cnt <= bit_cnt + CW'(1);
                        end else if (scl_fall && bit_cnt == CW'(AW + 1)) begin
                            // Match is resolved at the fall so the hit pulse lines up with ACK drive.
                            if (shift[AW:1] == own_addr_i) begin
                                addr_hit_o <= 1'b1;
                                op_o       <= shift[0];
                                sda_o      <= 1'b0;
                                state      <= ADDR_ACK;
                            end else begin
                                sda_o <= 1'b1;
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (op_o) begin
                                shift <= SW'(load_byte);
                                sda_o <= load_byte[DW-1];
                                if (tx_empty) tx_underrun_o <= 1'b1;
                                state <= RD_DATA;
                            end else begin
                                sda_o <= 1'b1;
                                state <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[SW-2:0], sda_s};
                            bit_cnt <= bit_cnt + CW'(1);
                            if (bit_cnt == CW'(DW - 1)) begin
                                ack_ok <= rx_space;
                                if (!rx_space) rx_overflow_o <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == CW'(DW)) begin
                            sda_o <= ~ack_ok;
                            state <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_o   <= 1'b1;
                            bit_cnt <= '0;
                            state   <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end else if (scl_fall) begin
                            if (bit_cnt == CW'(DW)) begin
                                sda_o <= 1'b1;
                                state <= RD_ACK;
                            end else begin
                                shift <= shift << 1;
                                sda_o <= shift[DW-2];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            nack <= sda_s;
                        end else if (scl_fall) begin
                            if (nack) begin
                                state <= IGNORE;
                            end else begin
                                shift   <= SW'(load_byte);
                                sda_o   <= load_byte[DW-1];
                                if (tx_empty) tx_underrun_o <= 1'b1;
                                bit_cnt <= '0;
                                state   <= RD_DATA;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_fifo.sv
// Directed bench for i2c_target_fifo: a scripted bus controller driven from a step table,
// plus a hand-written reset-during-read sequence.
module tb_i2c_target_fifo;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_o;
    logic [6:0] own_addr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       start_o, stop_o, addr_hit, op, busy, rx_overflow, tx_underrun;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & sda_o;

    i2c_target_fifo #(
        .I2C_ADDR_WIDTH(7),
        .I2C_DATA_WIDTH(8),
        .FIFO_DEPTH(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .scl_i(scl),
        .sda_i(sda_bus),
        .sda_o(sda_o),
        .own_addr_i(own_addr),
        .rx_data_o(rx_data),
        .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready),
        .tx_data_i(tx_data),
        .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready),
        .start_o(start_o),
        .stop_o(stop_o),
        .addr_hit_o(addr_hit),
        .op_o(op),
        .busy_o(busy),
        .rx_overflow_o(rx_overflow),
        .tx_underrun_o(tx_underrun)
    );

    int total = 0;
    int bad   = 0;
    int n_start = 0, n_stop = 0, n_hit = 0, n_low = 0;
    int b_start = 0, b_stop = 0, b_hit = 0, b_low = 0;

    always @(negedge clk) begin
        if (start_o)  n_start <= n_start + 1;
        if (stop_o)   n_stop  <= n_stop + 1;
        if (addr_hit) n_hit   <= n_hit + 1;
        if (!sda_o)   n_low   <= n_low + 1;
    end

    typedef enum int {
        K_OWN, K_START, K_STOP, K_WR, K_RD, K_PUSH, K_POP, K_EMPTY,
        K_FLAGS, K_PCNT, K_LOWCLR, K_NOLOW
    } kind_t;

    // d: byte driven/pushed (K_RD: controller ack bit; K_PCNT: {starts, stops});
    // e: expected value (K_WR: 1 = ACK; K_FLAGS: {busy, tx_ready, op, underrun, overflow}).
    typedef struct {
        kind_t      k;
        logic [7:0] d;
        logic [7:0] e;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input kind_t k, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.k = k;
        v.d = d;
        v.e = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sda_m = b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q / 2);
        r = sda_bus;
        wait_clk(Q - Q / 2);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(mack, r);
    endtask

    task automatic run_step(input vec_t v, input int idx);
        logic       a;
        logic [7:0] rd;
        string      nm;
        nm = $sformatf("step%0d_%s", idx, v.k.name());
        case (v.k)
            K_OWN:   own_addr = v.d[6:0];
            K_START: bus_start();
            K_STOP:  bus_stop();
            K_WR: begin
                write_byte(v.d, a);
                check(nm, 32'(a), 32'(v.e[0]));
            end
            K_RD: begin
                read_byte(v.d[0], rd);
                check(nm, 32'(rd), 32'(v.e));
            end
            K_PUSH: begin
                check(nm, 32'(tx_ready), 32'd1);
                tx_data  = v.d;
                tx_valid = 1'b1;
                wait_clk(1);
                tx_valid = 1'b0;
            end
            K_POP: begin
                check(nm, {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, v.e});
                rx_ready = 1'b1;
                wait_clk(1);
                rx_ready = 1'b0;
            end
            K_EMPTY: check(nm, 32'(rx_valid), 32'd0);
            K_FLAGS: check(nm, 32'({busy, tx_ready, op, tx_underrun, rx_overflow}), 32'(v.e[4:0]));
            K_PCNT: begin
                check(nm, {20'd0, 4'(n_start - b_start), 4'(n_stop - b_stop), 4'(n_hit - b_hit)},
                      {20'd0, v.d, v.e[3:0]});
                b_start = n_start;
                b_stop  = n_stop;
                b_hit   = n_hit;
            end
            K_LOWCLR: b_low = n_low;
            K_NOLOW:  check(nm, 32'(n_low - b_low), 32'd0);
            default: ;
        endcase
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        logic ack;
        int   idx;

        rst_n    = 1'b0;
        scl      = 1'b1;
        sda_m    = 1'b1;
        own_addr = 7'h22;
        rx_ready = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;

        // Write 0xA5, 0x3C to 0x22
        add(K_OWN, 8'h22, 8'h00);
        add(K_START, 8'h00, 8'h00);
        add(K_WR, 8'h44, 8'h01);
        add(K_WR, 8'hA5, 8'h01);
        add(K_WR, 8'h3C, 8'h01);
        add(K_STOP, 8'h00, 8'h00);
        add(K_PCNT, 8'h11, 8'h01);
        add(K_FLAGS, 8'h00, 8'b01000);
        add(K_POP, 8'h00, 8'hA5);
        add(K_POP, 8'h00, 8'h3C);
        add(K_EMPTY, 8'h00, 8'h00);
        // Read two preloaded bytes, ACK then NACK
        add(K_PUSH, 8'h5A, 8'h00);
        add(K_PUSH, 8'hC3, 8'h00);
        add(K_START, 8'h00, 8'h00);
        add(K_WR, 8'h45, 8'h01);
        add(K_RD, 8'h00, 8'h5A);
        add(K_RD, 8'h01, 8'hC3);
        add(K_STOP, 8'h00, 8'h00);
        add(K_FLAGS, 8'h00, 8'b01100);
        add(K_PCNT, 8'h11, 8'h01);
        // Foreign address 0x23: never driven, stays ignored until STOP
        add(K_LOWCLR, 8'h00, 8'h00);
        add(K_START, 8'h00, 8'h00);
        add(K_WR, 8'h46, 8'h00);
        add(K_WR, 8'h55, 8'h00);
        add(K_FLAGS, 8'h00, 8'b11100);
        add(K_STOP, 8'h00, 8'h00);
        add(K_NOLOW, 8'h00, 8'h00);
        add(K_FLAGS, 8'h00, 8'b01100);
        add(K_PCNT, 8'h11, 8'h00);
        // RX overflow at depth 4
        add(K_START, 8'h00, 8'h00);
        add(K_WR, 8'h44, 8'h01);
        add(K_WR, 8'h01, 8'h01);
        add(K_WR, 8'h02, 8'h01);
        add(K_WR, 8'h03, 8'h01);
        add(K_WR, 8'h04, 8'h01);
        add(K_WR, 8'h05, 8'h00);
        add(K_STOP, 8'h00, 8'h00);
        add(K_FLAGS, 8'h00, 8'b01001);
        add(K_PCNT, 8'h11, 8'h01);
        add(K_POP, 8'h00, 8'h01);
        add(K_POP, 8'h00, 8'h02);
        add(K_POP, 8'h00, 8'h03);
        add(K_POP, 8'h00, 8'h04);
        add(K_EMPTY, 8'h00, 8'h00);
        // Write, repeated START, read with TX empty
        add(K_START, 8'h00, 8'h00);
        add(K_WR, 8'h44, 8'h01);
        add(K_WR, 8'h10, 8'h01);
        add(K_START, 8'h00, 8'h00);
        add(K_WR, 8'h45, 8'h01);
        add(K_RD, 8'h01, 8'hFF);
        add(K_STOP, 8'h00, 8'h00);
        add(K_PCNT, 8'h21, 8'h02);
        add(K_FLAGS, 8'h00, 8'b01111);
        add(K_POP, 8'h00, 8'h10);
        add(K_EMPTY, 8'h00, 8'h00);

        wait_clk(3);
        check("reset_state", 32'({sda_o, start_o, stop_o, addr_hit, op, busy, rx_valid, tx_ready,
                                  rx_overflow, tx_underrun}), 32'b1000000100);
        rst_n = 1'b1;
        wait_clk(Q);

        idx = 0;
        foreach (vecs[i]) begin
            run_step(vecs[i], idx);
            idx++;
        end

        // Reset while the target drives a 0 read bit
        begin
            vec_t v;
            v.k = K_PUSH;
            v.d = 8'h00;
            v.e = 8'h00;
            run_step(v, idx);
        end
        bus_start();
        write_byte(8'h45, ack);
        check("rst_addr_ack", 32'(ack), 32'd1);
        sda_m = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q / 2);
        check("rst_drive_low", 32'(sda_o), 32'd0);
        rst_n = 1'b0;
        wait_clk(1);
        check("rst_release_sda", 32'(sda_o), 32'd1);
        check("rst_outputs", 32'({sda_o, start_o, stop_o, addr_hit, op, busy, rx_valid, tx_ready,
                                  rx_overflow, tx_underrun}), 32'b1000000100);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(Q);
        b_start = n_start;
        b_stop  = n_stop;
        b_hit   = n_hit;

        vecs.delete();
        add(K_START, 8'h00, 8'h00);
        add(K_WR, 8'h44, 8'h01);
        add(K_WR, 8'h77, 8'h01);
        add(K_STOP, 8'h00, 8'h00);
        add(K_POP, 8'h00, 8'h77);
        add(K_EMPTY, 8'h00, 8'h00);
        add(K_PCNT, 8'h11, 8'h01);
        add(K_FLAGS, 8'h00, 8'b01000);
        foreach (vecs[i]) begin
            run_step(vecs[i], idx + 100);
            idx++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target_fifo.md
Name: i2c_target_fifo

Overview:
- Synthesizable, parametrised I2C target (slave); the hardware successor of the behavioural I2C slave model.
- Detects START, repeated START and STOP; matches a 7-bit (parametrised) address; ACKs write bytes into an RX FIFO; serves read bytes from a TX FIFO.
- Sits between the I2C pins (open-drain, triand bus) and a local valid/ready byte interface; all logic runs on one system clock that oversamples SCL/SDA.

Parameters:
- I2C_ADDR_WIDTH, 7, target address width.
- I2C_DATA_WIDTH, 8, bits per data byte.
- FIFO_DEPTH, 16, entries in each of the RX and TX FIFOs (power of 2, ≥2).
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i (≥2).

Ports:
- clk_i  in  1  system clock; must be ≥16× SCL frequency.
- rst_n_i  in  1  synchronous, active-low reset.
- scl_i  in  1  bus SCL.
- sda_i  in  1  bus SDA.
- sda_o  out  1  open-drain drive: 0 = pull low, 1 = release (top level maps 1→'z').
- own_addr_i  in  I2C_ADDR_WIDTH  target address, sampled at each address phase.
- rx_data_o  out  I2C_DATA_WIDTH  received write byte (FIFO head).
- rx_valid_o  out  1  RX FIFO not empty.
- rx_ready_i  in  1  pop RX FIFO when rx_valid_o & rx_ready_i.
- tx_data_i  in  I2C_DATA_WIDTH  read byte to queue.
- tx_valid_i  in  1  push request.
- tx_ready_o  out  1  TX FIFO not full; push on tx_valid_i & tx_ready_o.
- start_o  out  1  one-cycle pulse on START or repeated START.
- stop_o  out  1  one-cycle pulse on STOP.
- addr_hit_o  out  1  one-cycle pulse when address matches (same cycle ACK drive begins).
- op_o  out  1  R/W bit of last matched address (1 = READ); holds until next match.
- busy_o  out  1  high from START to STOP.
- rx_overflow_o  out  1  sticky; set when a write byte is NACKed because RX is full; cleared by reset only.
- tx_underrun_o  out  1  sticky; set when a read byte is requested with TX empty; cleared by reset only.

Behaviour:
- Reset (rst_n_i low at a clk_i edge): sda_o=1, all pulses 0, op_o=0, busy_o=0, sticky flags 0, both FIFOs empty (rx_valid_o=0, tx_ready_o=1), FSM=IDLE. Reset mid-transfer releases SDA on the next clock.
- Synchronise SCL/SDA through SYNC_STAGES flops; an edge is a change between the last two synchronised samples. Pin-to-detect latency is SYNC_STAGES+1 clocks.
- START: SDA falls while SCL high; legal from any state. Pulses start_o, clears bit counter, goes to ADDR, releases SDA. STOP: SDA rises while SCL high. Pulses stop_o, busy_o=0, goes to IDLE. Both have priority over data sampling in the same cycle.
- Bits are sampled on SCL rising, MSB first. sda_o changes only in the cycle SCL falling is detected.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- ADDR: shift I2C_ADDR_WIDTH+1 bits. On match with own_addr_i: pulse addr_hit_o, latch op_o, drive 0 from next SCL fall for one SCL clock (ADDR_ACK). No match: release SDA, go to IGNORE until START/STOP.
- WR_DATA: shift I2C_DATA_WIDTH bits. After the last bit, push to RX if not full and ACK (WR_ACK). If RX is full, drop the byte, set rx_overflow_o and release SDA (NACK). Return to WR_DATA either way.
- RD_DATA: at the SCL fall ending ADDR_ACK/RD_ACK, pop the TX head and drive its bits MSB first (sda_o = bit). If TX is empty, send all-ones and set tx_underrun_o. RD_ACK: release SDA and sample the controller's bit on SCL rise: 0 (ACK) → next byte; 1 (NACK) → IGNORE.
- FIFOs: simultaneous push and pop in one cycle are both honoured, including at full (RX) or empty (TX) boundaries where the opposite side permits. Pointers wrap modulo FIFO_DEPTH. Local-side push to a full TX FIFO or pop from an empty RX FIFO is ignored.
- Clock stretching is not supported; SCL is never driven.

Test Plan:
- Write 0x22 (own_addr_i=0x22, W) then 0xA5, 0x3C, STOP → ACK on all three; rx_data_o pops 0xA5 then 0x3C; start_o, addr_hit_o and stop_o pulse once each; op_o=0.
- Preload TX with 0x5A, 0xC3; read from 0x22, controller ACKs the 1st byte and NACKs the 2nd → bus carries 0x5A, 0xC3; tx_ready_o=1; tx_underrun_o=0.
- Address 0x23 while own_addr_i=0x22 → SDA never driven low; addr_hit_o=0; FSM stays in IGNORE until STOP.
- FIFO_DEPTH=4, rx_ready_i=0, write 5 bytes 0x01–0x05 → first 4 ACKed, 5th NACKed; rx_overflow_o=1; RX holds 0x01–0x04.
- Write 0x10, repeated START, read with TX empty → start_o pulses twice; read byte 0xFF; tx_underrun_o=1; RX holds 0x10.
- Assert rst_n_i while driving a read bit of 0 → sda_o=1 next clock; all outputs at reset values; next transfer works normally.
